ram_boot_loader: RTL
====================

Name: ram_boot_loader

Overview:
- Parametrised program/data loader that owns the RAM bus at start-up.
- Accepts (address, word) beats on a valid/ready stream and writes them into RAM. Optionally reads every loaded word back and checks it.
- Hands the RAM bus to the CU and raises cu_enable only after a clean load.
- Replaces the hand-muxed preload path between bench/boot logic, CUmodule and RAMblock.

Parameters:
- DATA_W, 16, RAM/databus word width.
- ADDR_W, 5, RAM address width.
- MAX_WORDS, 32, depth of the verify shadow buffer (words per load).
- RD_LAT, 1, RAM read latency in clk cycles (ram_read edge to ram_rdata valid).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a new load session.
- verify_en  in  1  sampled on start; 1 = read-back check after load.
- s_valid  in  1  load beat valid.
- s_ready  out  1  loader accepts a beat.
- s_addr  in  ADDR_W  target RAM address.
- s_data  in  DATA_W  word to write.
- s_last  in  1  marks the final beat of the session.
- cu_enable  out  1  CU run enable.
- cu_addr  in  ADDR_W  CU address bus.
- cu_wdata  in  DATA_W  CU write data.
- cu_read  in  1  CU read strobe.
- cu_write  in  1  CU write strobe.
- cu_rdata  out  DATA_W  RAM read data returned to the CU.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- ram_read  out  1  RAM read strobe.
- ram_write  out  1  RAM write strobe.
- busy  out  1  LOAD or VERIFY in progress.
- done  out  1  sticky; session passed, CU running.
- error  out  1  sticky; verify mismatch or buffer overflow.
- err_addr  out  ADDR_W  address of the first failure.
- word_count  out  clog2(MAX_WORDS)+1  beats accepted this session.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - cu_enable, s_ready, ram_read, ram_write, busy, done and error are 0.
  - ram_addr, ram_wdata, err_addr and word_count are 0.
  - Shadow buffer is emptied.
- Reset mid-session aborts immediately. Nothing further is written to RAM.
- States: IDLE, LOAD, VERIFY, RUN, ERROR.
- IDLE:
  - The loader owns the bus with ram_read=ram_write=0. cu_rdata=0.
  - start -> LOAD: clear done, error and word_count; latch verify_en.
- LOAD:
  - s_ready=1 except on the cycle after a handshake, so there is at most one beat every 2 cycles.
  - On handshake: next edge ram_addr<=s_addr, ram_wdata<=s_data, ram_write=1 for exactly one cycle, word_count+1.
  - If verify is latched, push {s_addr,s_data} into the shadow buffer.
  - Write latency from handshake to ram_write is 1 cycle.
  - Overflow: a handshake when word_count==MAX_WORDS with verify latched goes to ERROR. err_addr=s_addr; the beat is not written.
  - Without verify there is no count limit; word_count saturates.
  - Handshake with s_last: after its write cycle, go to VERIFY (if verify is latched) or RUN.
  - A handshake carrying the same address as an earlier beat overwrites RAM. Verify checks the last value written to that address, so the shadow entry is updated in place, not appended.
- VERIFY:
  - Entries are popped in order of first occurrence.
  - For each entry: drive ram_addr and ram_read=1 for 1 cycle, wait RD_LAT cycles, then compare ram_rdata with the stored data.
  - Mismatch -> ERROR, err_addr = entry address.
  - Buffer empty -> RUN.
  - Per-word cost is RD_LAT+1 cycles.
- RUN:
  - cu_enable=1 and done=1.
  - ram_addr/ram_wdata/ram_read/ram_write = cu_* combinationally; cu_rdata=ram_rdata.
- ERROR:
  - cu_enable=0; the bus is held idle; error=1 until the next start or reset.
- start in any state other than IDLE, including RUN and ERROR:
  - Go to LOAD at the next edge. cu_enable drops at that same edge.
  - Clear done and error; empty the buffer.
  - A handshake coinciding with start is ignored (s_ready=0 in IDLE, RUN and ERROR).
- s_valid while not in LOAD: ignored. s_ready=0.
- busy=1 only in LOAD and VERIFY.

Test Plan:
- Reset, then start with verify_en=0. Beats (16,5), (17,2), (1,0x086), (2,0x18E), (3,0 last) -> five single-cycle ram_write pulses each one cycle after its handshake, word_count=5, then RUN. The CU then executes and writes its result. s_ready never high two cycles in a row.
- Same load with verify_en=1 and a correct RAM model -> five reads spaced RD_LAT+1 apart, then done=1, cu_enable=1, error=0.
- verify_en=1 with the RAM model corrupting address 17 (returns 3) -> ERROR, err_addr=17, cu_enable stays 0. The next start clears error.
- verify_en=1 with MAX_WORDS=4 and 5 beats -> error on the 5th handshake, err_addr = 5th address, no 5th write.
- Duplicate address: (4,0xAAAA) then (4,0x5555 last) with verify -> only 0x5555 is checked; pass.
- Assert rst_n low mid-LOAD after 2 beats -> all outputs go to reset values without waiting for a clock edge. start then reloads cleanly.

Source files
------------

// File: rtl/ram_boot_loader.sv
// Boot-time loader that owns the RAM bus: streams (addr, word) beats into RAM,
// optionally reads them back against a shadow copy, then hands the bus to the CU.
module ram_boot_loader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 5,
    parameter int MAX_WORDS = 32,
    parameter int RD_LAT    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         verify_en,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [ADDR_W-1:0]            s_addr,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_last,
    output logic                         cu_enable,
    input  logic [ADDR_W-1:0]            cu_addr,
    input  logic [DATA_W-1:0]            cu_wdata,
    input  logic                         cu_read,
    input  logic                         cu_write,
    output logic [DATA_W-1:0]            cu_rdata,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [DATA_W-1:0]            ram_wdata,
    input  logic [DATA_W-1:0]            ram_rdata,
    output logic                         ram_read,
    output logic                         ram_write,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [ADDR_W-1:0]            err_addr,
    output logic [$clog2(MAX_WORDS):0]   word_count
);
    localparam int CW = $clog2(MAX_WORDS) + 1;
    localparam int IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int LW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RUN, ERROR} state_t;
    state_t state_reg, state_next;

    logic              verify_reg, hs_prev_reg, last_pend_reg;
    logic              ram_read_reg, ram_write_reg, done_reg, error_reg;
    logic [ADDR_W-1:0] ram_addr_reg, err_addr_reg;
    logic [DATA_W-1:0] ram_wdata_reg;
    logic [CW-1:0]     word_count_reg, sh_count_reg;
    logic [IW-1:0]     vidx_reg;
    logic [LW-1:0]     wait_reg;

    logic [ADDR_W-1:0] sh_addr_mem [MAX_WORDS];
    logic [DATA_W-1:0] sh_data_mem [MAX_WORDS];

    logic                 hs, overflow, push, any_match, cmp_now, mismatch, last_entry;
    logic [MAX_WORDS-1:0] match, wr_sel;
    logic [ADDR_W-1:0]    cur_addr;
    logic [DATA_W-1:0]    cur_data;

    assign s_ready    = (state_reg == LOAD) && !hs_prev_reg && !start;
    assign hs         = s_valid && s_ready;
    assign overflow   = hs && verify_reg && (word_count_reg == CW'(MAX_WORDS));
    assign push       = hs && !overflow && verify_reg;
    assign cur_addr   = sh_addr_mem[vidx_reg];
    assign cur_data   = sh_data_mem[vidx_reg];
    assign cmp_now    = (state_reg == VERIFY) && !ram_read_reg && (wait_reg == LW'(RD_LAT));
    assign mismatch   = cmp_now && (ram_rdata != cur_data);
    assign last_entry = ((CW'(vidx_reg) + 1'b1) == sh_count_reg);
    assign any_match  = |match;

    // Shadow buffer keeps one entry per distinct address, in first-seen order;
    // a repeated address rewrites its entry so verify checks the final value.
    generate
        for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_shadow
            assign match[gi]  = (CW'(gi) < sh_count_reg) && (sh_addr_mem[gi] == s_addr);
            assign wr_sel[gi] = push && (match[gi] || (!any_match && (sh_count_reg == CW'(gi))));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (wr_sel[i]) begin
                sh_addr_mem[i] <= s_addr;
                sh_data_mem[i] <= s_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (overflow)
                        state_next = ERROR;
                    else if (last_pend_reg)
                        state_next = (verify_reg && (sh_count_reg != '0)) ? VERIFY : RUN;
                end
                VERIFY: begin
                    if (mismatch)
                        state_next = ERROR;
                    else if (cmp_now && last_entry)
                        state_next = RUN;
                end
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            verify_reg     <= 1'b0;
            hs_prev_reg    <= 1'b0;
            last_pend_reg  <= 1'b0;
            ram_read_reg   <= 1'b0;
            ram_write_reg  <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
            err_addr_reg   <= '0;
            word_count_reg <= '0;
            sh_count_reg   <= '0;
            vidx_reg       <= '0;
            wait_reg       <= '0;
        end else begin
            ram_write_reg <= 1'b0;
            hs_prev_reg   <= hs;
            last_pend_reg <= hs && !overflow && s_last;
            if (start) begin
                verify_reg     <= verify_en;
                word_count_reg <= '0;
                done_reg       <= 1'b0;
                error_reg      <= 1'b0;
                sh_count_reg   <= '0;
                ram_read_reg   <= 1'b0;
                wait_reg       <= '0;
            end else begin
                if (hs && !overflow) begin
                    ram_addr_reg  <= s_addr;
                    ram_wdata_reg <= s_data;
                    ram_write_reg <= 1'b1;
                    if (word_count_reg != '1)
                        word_count_reg <= word_count_reg + 1'b1;
                end
                if (push && !any_match)
                    sh_count_reg <= sh_count_reg + 1'b1;
                if (overflow)
                    err_addr_reg <= s_addr;
                // First read-back is issued on the same edge that leaves the last write cycle.
                if ((state_reg == LOAD) && (state_next == VERIFY)) begin
                    ram_read_reg <= 1'b1;
                    ram_addr_reg <= sh_addr_mem[0];
                    vidx_reg     <= '0;
                end
                if (state_reg == VERIFY) begin
                    if (ram_read_reg) begin
                        ram_read_reg <= 1'b0;
                        wait_reg     <= LW'(1);
                    end else if (!cmp_now) begin
                        wait_reg <= wait_reg + 1'b1;
                    end else if (mismatch) begin
                        err_addr_reg <= cur_addr;
                    end else if (!last_entry) begin
                        vidx_reg     <= vidx_reg + 1'b1;
                        ram_read_reg <= 1'b1;
                        ram_addr_reg <= sh_addr_mem[vidx_reg + 1'b1];
                    end
                end
                if ((state_next == RUN) && (state_reg != RUN))
                    done_reg <= 1'b1;
                if ((state_next == ERROR) && (state_reg != ERROR))
                    error_reg <= 1'b1;
            end
        end
    end

    // In RUN the CU drives the RAM directly; elsewhere the loader's registers do.
    assign cu_enable  = (state_reg == RUN);
    assign ram_addr   = cu_enable ? cu_addr  : ram_addr_reg;
    assign ram_wdata  = cu_enable ? cu_wdata : ram_wdata_reg;
    assign ram_read   = cu_enable ? cu_read  : ram_read_reg;
    assign ram_write  = cu_enable ? cu_write : ram_write_reg;
    assign cu_rdata   = cu_enable ? ram_rdata : '0;
    assign busy       = (state_reg == LOAD) || (state_reg == VERIFY);
    assign done       = done_reg;
    assign error      = error_reg;
    assign err_addr   = err_addr_reg;
    assign word_count = word_count_reg;

endmodule
